// File: rtl/uart_dl_packet_rx_pkg.sv
// Shared types and constants for the UART download packet deframer.
package uart_dl_packet_rx_pkg;

  localparam int unsigned PKT_DATA_BYTES = 32;
  localparam int unsigned WORDS_PER_PKT  = PKT_DATA_BYTES / 4;

  localparam logic [7:0]  ACK_BYTE = 8'h06;
  localparam logic [7:0]  NAK_BYTE = 8'h15;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'hA001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_WRITE,
    ST_RESP,
    ST_DONE
  } state_e;

  // ROM write port payload
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_wr_t;

endpackage

// File: rtl/uart_dl_crc16.sv
// Single-byte Modbus CRC16 update (reflected poly A001), unrolled over 8 bits.
//   crc_in    : running CRC
//   data_in   : next byte
//   crc_out_c : CRC after absorbing data_in (combinational)
module uart_dl_crc16
  import uart_dl_packet_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out_c
);

  always_comb begin
    crc_out_c = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++) begin
      crc_out_c = crc_out_c[0] ? ((crc_out_c >> 1) ^ CRC_POLY) : (crc_out_c >> 1);
    end
  end

endmodule

// File: rtl/uart_dl_packet_rx.sv
// UART download packet deframer: parses seq/32 data/CRC16 packets, checks CRC
// and sequence, writes payload words to ROM and queues an ACK/NAK byte.
//   clk, rst         : clock, async active-low reset
//   enable           : debug pin; low forces IDLE and clears the session
//   rx_valid/rx_data : byte strobe from the UART receiver
//   tx_valid/tx_data/tx_ready : response byte handshake to the transmitter
//   mem_we/mem_addr/mem_wdata : ROM word write port
//   file_size, busy, done, rx_overrun : status
module uart_dl_packet_rx
  import uart_dl_packet_rx_pkg::*;
#(
  parameter int unsigned FILE_SIZE_IDX  = 28,
  parameter logic [31:0] ROM_BASE       = 32'h0000_0000,
  parameter int unsigned MAX_BYTES      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] file_size,
  output logic        busy,
  output logic        done,
  output logic        rx_overrun
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W = 6;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        seq_q, seq_d;
  logic [7:0]        exp_seq_q, exp_seq_d;
  logic [15:0]       crc_q, crc_d;
  logic [15:0]       crc_rx_q, crc_rx_d;
  logic [2:0]        w_q, w_d;
  logic              wrote_q, wrote_d;
  logic [31:0]       file_size_q, file_size_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  mem_wr_t           mem_q, mem_d;

  logic [7:0]        pkt_buf [PKT_DATA_BYTES];
  logic              buf_we_c;
  logic              emit_c;
  logic [2:0]        wr_idx_c;
  logic [31:0]       wr_off_c;
  logic [31:0]       size_c;
  logic [15:0]       crc_upd_c;

  uart_dl_crc16 u_crc (
    .crc_in    (crc_q),
    .data_in   (rx_data),
    .crc_out_c (crc_upd_c)
  );

  // Big-endian file size carried in packet 0
  assign size_c = {pkt_buf[5'(FILE_SIZE_IDX)],     pkt_buf[5'(FILE_SIZE_IDX + 1)],
                   pkt_buf[5'(FILE_SIZE_IDX + 2)], pkt_buf[5'(FILE_SIZE_IDX + 3)]};

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    gap_d       = gap_q;
    seq_d       = seq_q;
    exp_seq_d   = exp_seq_q;
    crc_d       = crc_q;
    crc_rx_d    = crc_rx_q;
    w_d         = w_q;
    wrote_d     = wrote_q;
    file_size_d = file_size_q;
    overrun_d   = overrun_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    mem_d       = mem_q;
    mem_d.we    = 1'b0;
    buf_we_c    = 1'b0;
    emit_c      = 1'b0;
    wr_idx_c    = 3'd0;
    wr_off_c    = 32'd0;

    if (rx_valid && (state_q inside {ST_CHECK, ST_WRITE, ST_RESP})) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          seq_d      = rx_data;
          byte_cnt_d = '0;
          crc_d      = CRC_INIT;
          gap_d      = '0;
          state_d    = ST_RECV;
        end
      end
      ST_RECV: begin
        if (rx_valid) begin
          gap_d      = '0;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          if (byte_cnt_q < CNT_W'(PKT_DATA_BYTES)) begin
            buf_we_c = 1'b1;
            crc_d    = crc_upd_c;
          end else if (byte_cnt_q == CNT_W'(PKT_DATA_BYTES)) begin
            crc_rx_d[7:0] = rx_data;
          end else begin
            crc_rx_d[15:8] = rx_data;
            state_d        = ST_CHECK;
          end
        end else if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_CHECK: begin
        wrote_d    = 1'b0;
        tx_valid_d = 1'b1;
        tx_data_d  = NAK_BYTE;
        state_d    = ST_RESP;
        if (crc_q != crc_rx_q) begin
          tx_data_d = NAK_BYTE;
        end else if ((exp_seq_q != 8'd0) && (seq_q == exp_seq_q - 8'd1)) begin
          tx_data_d = ACK_BYTE;
        end else if (seq_q != exp_seq_q) begin
          tx_data_d = NAK_BYTE;
        end else if (seq_q == 8'd0) begin
          file_size_d = size_c;
          if ((size_c != 32'd0) && (size_c <= 32'(MAX_BYTES))) begin
            tx_data_d = ACK_BYTE;
            exp_seq_d = 8'd1;
          end
        end else begin
          tx_valid_d = 1'b0;
          state_d    = ST_WRITE;
          w_d        = 3'd0;
          emit_c     = 1'b1;
          wr_idx_c   = 3'd0;
        end
      end
      ST_WRITE: begin
        // Outputs for word w are already on the port; prepare w+1 or the ACK
        if (w_q == 3'(WORDS_PER_PKT - 1)) begin
          exp_seq_d  = exp_seq_q + 8'd1;
          wrote_d    = 1'b1;
          tx_valid_d = 1'b1;
          tx_data_d  = ACK_BYTE;
          state_d    = ST_RESP;
        end else begin
          w_d      = w_q + 3'd1;
          emit_c   = 1'b1;
          wr_idx_c = w_q + 3'd1;
        end
      end
      ST_RESP: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (wrote_q && (32'(exp_seq_q - 8'd1) >=
              (file_size_q + 32'(PKT_DATA_BYTES - 1)) / 32'(PKT_DATA_BYTES))) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Word write: strobe only while the word lies inside the file
    if (emit_c) begin
      wr_off_c    = 32'(seq_q - 8'd1) * 32'(PKT_DATA_BYTES) + 32'({wr_idx_c, 2'b00});
      mem_d.addr  = ROM_BASE + wr_off_c;
      mem_d.wdata = {pkt_buf[{wr_idx_c, 2'b11}], pkt_buf[{wr_idx_c, 2'b10}],
                     pkt_buf[{wr_idx_c, 2'b01}], pkt_buf[{wr_idx_c, 2'b00}]};
      mem_d.we    = (wr_off_c < file_size_q);
    end

    // Debug pin low overrides everything
    if (!enable) begin
      state_d     = ST_IDLE;
      exp_seq_d   = 8'd0;
      file_size_d = 32'd0;
      overrun_d   = 1'b0;
      tx_valid_d  = 1'b0;
      mem_d.we    = 1'b0;
      buf_we_c    = 1'b0;
    end

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      gap_q       <= '0;
      seq_q       <= 8'd0;
      exp_seq_q   <= 8'd0;
      crc_q       <= CRC_INIT;
      crc_rx_q    <= 16'd0;
      w_q         <= 3'd0;
      wrote_q     <= 1'b0;
      file_size_q <= 32'd0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      busy_q      <= 1'b0;
      mem_q       <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      gap_q       <= gap_d;
      seq_q       <= seq_d;
      exp_seq_q   <= exp_seq_d;
      crc_q       <= crc_d;
      crc_rx_q    <= crc_rx_d;
      w_q         <= w_d;
      wrote_q     <= wrote_d;
      file_size_q <= file_size_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      mem_q       <= mem_d;
    end
  end

  // Payload buffer (no reset needed; always refilled before use)
  always_ff @(posedge clk) begin
    if (buf_we_c) pkt_buf[byte_cnt_q[4:0]] <= rx_data;
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign mem_we     = mem_q.we;
  assign mem_addr   = mem_q.addr;
  assign mem_wdata  = mem_q.wdata;
  assign file_size  = file_size_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rx_overrun = overrun_q;

endmodule

// File: doc/uart_dl_packet_rx.md
Name: uart_dl_packet_rx

Overview:
Packet deframer for the UART download path. It consumes the byte stream from the UART receiver while the debug pin is high and parses fixed-size packets (sequence byte, 32 data bytes, CRC16 low byte, CRC16 high byte). It checks the CRC and the sequence number, writes verified payload words into instruction ROM, and returns an ACK or NAK byte to the UART transmitter. It sits between the UART byte receiver/transmitter and the ROM write port inside the SoC debug logic.

Parameters:
PKT_DATA_BYTES, 32, payload bytes per packet (fixed multiple of 4)
FILE_SIZE_IDX, 28, byte index in packet 0 of the 4-byte big-endian file size
ROM_BASE, 32'h0000_0000, byte address of ROM word 0
MAX_BYTES, 1024, largest accepted file size (must be ≤ 255*PKT_DATA_BYTES)
TIMEOUT_CYCLES, 50000, allowed inter-byte gap mid-packet (1 ms at 50 MHz)
ACK_BYTE, 8'h06, response for an accepted packet
NAK_BYTE, 8'h15, response for a rejected packet

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active low
enable  in  1  debug pin; low forces IDLE and clears session state
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received byte
tx_valid  out  1  response byte pending
tx_data  out  8  response byte (ACK_BYTE or NAK_BYTE)
tx_ready  in  1  transmitter accepted tx_data
mem_we  out  1  ROM word write strobe
mem_addr  out  32  ROM byte address, word-aligned
mem_wdata  out  32  little-endian assembled word
file_size  out  32  size latched from packet 0
busy  out  1  state != IDLE and state != DONE
done  out  1  all file bytes written
rx_overrun  out  1  sticky: byte arrived in CHECK/WRITE/RESP and was dropped

Behaviour:
- Reset: every output 0; exp_seq=0; state IDLE. Reset is asynchronous and may assert mid-packet; outputs clear immediately.
- enable=0: next state IDLE; exp_seq, file_size, done and rx_overrun cleared; tx_valid and mem_we deassert. This takes priority over all other transitions.
- States: IDLE, RECV, CHECK, WRITE, RESP, DONE.
- IDLE: rx_valid loads the seq byte, sets byte_cnt=0, sets crc=16'hFFFF, then goes to RECV.
- RECV: data bytes go into a 32-byte buffer and update the CRC (Modbus: poly A001 reflected, init FFFF, covers the data bytes only). Then the CRC lo and CRC hi bytes are captured. On the rx_valid carrying CRC hi, go to CHECK.
- Timeout: in RECV, a gap counter is cleared on each rx_valid. When it reaches TIMEOUT_CYCLES, return to IDLE silently. No response is sent and no state changes.
- CHECK (1 cycle):
  - CRC mismatch: NAK.
  - seq==exp_seq-1 with exp_seq>0 (retransmission): ACK, no writes.
  - seq!=exp_seq: NAK.
  - Packet 0: latch big-endian size. Size==0 or size>MAX_BYTES gives NAK. Otherwise ACK and exp_seq=1.
  - Data packet: go to WRITE.
- WRITE: 8 cycles, w=0..7. Each cycle drives mem_we=1, mem_addr=ROM_BASE+(seq-1)*32+4w, mem_wdata={b[4w+3],b[4w+2],b[4w+1],b[4w]}. The strobe is suppressed when (seq-1)*32+4w ≥ file_size. After w=7: exp_seq++, ACK.
- RESP: tx_valid=1 and tx_data stable until tx_ready. On the handshake:
  - If the ACK followed a write and exp_seq-1 ≥ ceil(file_size/32), go to DONE.
  - Otherwise go to IDLE.
- DONE: done=1; rx bytes are ignored (not overrun). Exit only via enable low.
- Latency: CRC-hi rx_valid in cycle N. CHECK at N+1. Writes at N+2..N+9. tx_valid at N+10. A NAK or non-writing ACK asserts tx_valid at N+2.
- rx_valid during CHECK/WRITE/RESP: byte dropped, rx_overrun=1.
- Widths: seq is 8 bits and exp_seq is 8 bits. The MAX_BYTES bound guarantees no wrap. Address arithmetic is 32-bit.

Decomposition:
- Shared package/defines: state encoding, ACK/NAK constants, CRC init (16'hFFFF) and poly (16'hA001).
- Sub-module uart_dl_crc16: combinational single-byte Modbus CRC update (crc_in[15:0], byte[7:0] -> crc_out[15:0]), unrolled over 8 bits.

Test Plan:
- uart_dl_crc16 fed ASCII "123456789" sequentially from FFFF -> final CRC 16'h4B37.
- Packet 0 with size 64, then packets 1 and 2 with correct CRC:
  - Each packet gets ACK 0x06.
  - 16 mem_we writes at addresses 0x00..0x3C with little-endian data.
  - done=1 after the second ACK.
- Packet 1 with CRC hi byte XOR 0x01 -> NAK 0x15, zero mem_we, exp_seq unchanged. Resend correct -> ACK and 8 writes.
- After packet 1 is ACKed, resend packet 1:
  - ACK with no mem_we.
  - Packet 3 sent instead of 2 -> NAK.
  - file_size 40 -> packet 2 writes only words 0x20 and 0x24.
- Stall 60000 cycles after 10 data bytes -> silent return to IDLE. A full retransmitted packet is then ACKed. Then drop enable mid-packet -> state IDLE, done=0, exp_seq=0.
- Packet 0 with size 2000 -> NAK. Hold tx_ready=0 for 20 cycles -> tx_valid/tx_data held at 0x15. Bytes sent meanwhile set rx_overrun=1.
